// File: rtl/mctrl_pkg.sv
// Shared definitions for the multicycle controller: FSM states, opcodes,
// ALU operation codes and the decoded-control record.
package mctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_t;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic       illegal;
        logic       is_alu;
        logic       is_load;
        logic       is_store;
        logic       is_branch;
        logic       is_jalr;
        logic       alusrc_a;
        logic       alusrc_b;
        logic       taken;
        logic [3:0] alu_ctrl;
    } ctrl_t;

    // alt is funct7[5]; it selects SUB only for register-register ops
    function automatic logic [3:0] alu_from_funct3(input logic [2:0] funct3,
                                                   input logic       alt,
                                                   input logic       is_reg);
        logic [3:0] code;
        case (funct3)
            3'b000:  code = (alt && is_reg) ? ALU_SUB : ALU_ADD;
            3'b001:  code = ALU_SLL;
            3'b010:  code = ALU_SLT;
            3'b011:  code = ALU_SLTU;
            3'b100:  code = ALU_XOR;
            3'b101:  code = alt ? ALU_SRA : ALU_SRL;
            3'b110:  code = ALU_OR;
            default: code = ALU_AND;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/mctrl_decoder.sv
// Combinational instruction decode: instruction class, ALU operand/op selects
// and branch outcome from the datapath flags.
module mctrl_decoder
    import mctrl_pkg::*;
(
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        lsb,
    output ctrl_t       ctrl
);

    logic [2:0] funct3;
    logic       flag;
    logic       unused_fields;

    assign funct3        = instr[14:12];
    assign unused_fields = ^{instr[31], instr[29:15], instr[11:7]};

    // Signed/unsigned compares report through the ALU result LSB, equality through zero
    assign flag = funct3[2] ? lsb : zero;

    always_comb begin
        ctrl          = '0;
        ctrl.alu_ctrl = ALU_ADD;
        case (instr[6:0])
            OP_RTYPE: begin
                ctrl.is_alu   = 1'b1;
                ctrl.alusrc_a = 1'b1;
                ctrl.alu_ctrl = alu_from_funct3(funct3, instr[30], 1'b1);
            end
            OP_ITYPE: begin
                ctrl.is_alu   = 1'b1;
                ctrl.alusrc_a = 1'b1;
                ctrl.alusrc_b = 1'b1;
                ctrl.alu_ctrl = alu_from_funct3(funct3, instr[30], 1'b0);
            end
            OP_LOAD: begin
                ctrl.is_load  = 1'b1;
                ctrl.alusrc_a = 1'b1;
                ctrl.alusrc_b = 1'b1;
            end
            OP_STORE: begin
                ctrl.is_store = 1'b1;
                ctrl.alusrc_a = 1'b1;
                ctrl.alusrc_b = 1'b1;
            end
            OP_BRANCH: begin
                ctrl.is_branch = 1'b1;
                ctrl.alusrc_a  = 1'b1;
                ctrl.alu_ctrl  = funct3[2] ? (funct3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
                ctrl.taken     = flag ^ funct3[0];
            end
            OP_JALR: begin
                ctrl.is_jalr  = 1'b1;
                ctrl.alusrc_a = 1'b1;
                ctrl.alusrc_b = 1'b1;
            end
            default: ctrl.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM with instruction/data memory handshakes.
// Optional MCTRL_PERF_CNT_EN adds retired_cnt/stall_cnt performance counters.
module multicycle_ctrl
    import mctrl_pkg::*;
(
    input  logic        clock,
    input  logic        reset_,
    input  logic        run,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    output logic [31:0] instr,
    input  logic        zero,
    input  logic        LSb_aluresult,
    output logic        pc_en,
    output logic        regwrite,
    output logic        memtoreg,
    output logic        alusrcA,
    output logic        alusrcB,
    output logic        selBranch,
    output logic        jump,
    output logic [3:0]  aluControl,
    output logic        illegal_instr,
    output logic        halted
`ifdef MCTRL_PERF_CNT_EN
    ,
    output logic [31:0] retired_cnt,
    output logic [31:0] stall_cnt
`endif
);

    state_t state_reg;
    ctrl_t  ctrl;

    mctrl_decoder u_decoder (
        .instr (instr),
        .zero  (zero),
        .lsb   (LSb_aluresult),
        .ctrl  (ctrl)
    );

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state_reg  <= S_IDLE;
            imem_req   <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            instr      <= NOP_INSTR;
            regwrite   <= 1'b0;
            memtoreg   <= 1'b0;
            alusrcA    <= 1'b0;
            alusrcB    <= 1'b0;
            aluControl <= ALU_ADD;
            halted     <= 1'b1;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (run) begin
                        state_reg <= S_FETCH;
                        imem_req  <= 1'b1;
                        halted    <= 1'b0;
                    end
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        instr     <= imem_rdata;
                        imem_req  <= 1'b0;
                        state_reg <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (ctrl.illegal) begin
                        if (run) begin
                            state_reg <= S_FETCH;
                            imem_req  <= 1'b1;
                        end else begin
                            state_reg <= S_IDLE;
                            halted    <= 1'b1;
                        end
                    end else begin
                        state_reg  <= S_EXEC;
                        alusrcA    <= ctrl.alusrc_a;
                        alusrcB    <= ctrl.alusrc_b;
                        aluControl <= ctrl.alu_ctrl;
                    end
                end
                S_EXEC: begin
                    if (ctrl.is_load || ctrl.is_store) begin
                        state_reg <= S_MEM;
                        dmem_req  <= 1'b1;
                        dmem_we   <= ctrl.is_store;
                    end else if (ctrl.is_alu) begin
                        state_reg <= S_WB;
                        regwrite  <= 1'b1;
                    end else begin
                        state_reg <= S_FETCH;
                        imem_req  <= 1'b1;
                    end
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        if (ctrl.is_store) begin
                            state_reg <= S_FETCH;
                            imem_req  <= 1'b1;
                        end else begin
                            state_reg <= S_WB;
                            regwrite  <= 1'b1;
                            memtoreg  <= 1'b1;
                        end
                    end
                end
                S_WB: begin
                    regwrite <= 1'b0;
                    memtoreg <= 1'b0;
                    if (run) begin
                        state_reg <= S_FETCH;
                        imem_req  <= 1'b1;
                    end else begin
                        state_reg <= S_IDLE;
                        halted    <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                    imem_req  <= 1'b0;
                    dmem_req  <= 1'b0;
                    halted    <= 1'b1;
                end
            endcase
        end
    end

    // PC strobes depend on same-cycle flags/acks, so they are decoded from the state
    always_comb begin
        pc_en         = 1'b0;
        selBranch     = 1'b0;
        jump          = 1'b0;
        illegal_instr = 1'b0;
        case (state_reg)
            S_DECODE: begin
                illegal_instr = ctrl.illegal;
                pc_en         = ctrl.illegal;
            end
            S_EXEC: begin
                pc_en     = ctrl.is_branch | ctrl.is_jalr;
                selBranch = ctrl.is_branch & ctrl.taken;
                jump      = ctrl.is_jalr;
            end
            S_MEM:   pc_en = ctrl.is_store & dmem_ack;
            S_WB:    pc_en = 1'b1;
            default: pc_en = 1'b0;
        endcase
    end

`ifdef MCTRL_PERF_CNT_EN
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            retired_cnt <= '0;
            stall_cnt   <= '0;
        end else begin
            if (pc_en) begin
                retired_cnt <= retired_cnt + 32'd1;
            end
            if ((imem_req && !imem_ack) || (dmem_req && !dmem_ack)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized self-checking bench for multicycle_ctrl: a per-instruction trace
// model predicts every cycle's outputs; a compare process checks them.
module tb_multicycle_ctrl;

    logic        clock = 1'b0;
    logic        reset_ = 1'b0;
    logic        run = 1'b0;
    logic        imem_ack = 1'b0;
    logic        dmem_ack = 1'b0;
    logic        zero = 1'b0;
    logic        LSb_aluresult = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        imem_req, dmem_req, dmem_we;
    logic [31:0] instr;
    logic        pc_en, regwrite, memtoreg, alusrcA, alusrcB, selBranch, jump;
    logic [3:0]  aluControl;
    logic        illegal_instr, halted;
`ifdef MCTRL_PERF_CNT_EN
    logic [31:0] retired_cnt, stall_cnt;
`endif

    always #5 clock = ~clock;

    multicycle_ctrl dut (
        .clock         (clock),
        .reset_        (reset_),
        .run           (run),
        .imem_req      (imem_req),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_ack      (dmem_ack),
        .instr         (instr),
        .zero          (zero),
        .LSb_aluresult (LSb_aluresult),
        .pc_en         (pc_en),
        .regwrite      (regwrite),
        .memtoreg      (memtoreg),
        .alusrcA       (alusrcA),
        .alusrcB       (alusrcB),
        .selBranch     (selBranch),
        .jump          (jump),
        .aluControl    (aluControl),
        .illegal_instr (illegal_instr),
        .halted        (halted)
`ifdef MCTRL_PERF_CNT_EN
        ,
        .retired_cnt   (retired_cnt),
        .stall_cnt     (stall_cnt)
`endif
    );

    // One cycle of stimulus plus the outputs the model requires for that cycle
    typedef struct {
        bit        run, iack, dack, z, l;
        bit [31:0] rdata;
        bit        imem_req, dmem_req, dmem_we, pc_en, regwrite, memtoreg;
        bit        selb, jump, ill, halted;
        bit        chk_alu, chk_ab, a, b;
        bit [3:0]  alu;
        bit        chk_instr;
        bit [31:0] instr;
    } cyc_t;

    cyc_t drive_q[$];
    cyc_t cmp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    // Instruction class: 0 R, 1 I-ALU, 2 load, 3 store, 4 branch, 5 JALR, 6 illegal
    function automatic int iclass(input logic [31:0] ins);
        case (ins[6:0])
            7'h33:   return 0;
            7'h13:   return 1;
            7'h03:   return 2;
            7'h23:   return 3;
            7'h63:   return 4;
            7'h67:   return 5;
            default: return 6;
        endcase
    endfunction

    function automatic logic [3:0] exp_alu(input logic [31:0] ins);
        logic [3:0] tbl [8];
        int c, f3;
        bit alt;
        tbl = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};
        c   = iclass(ins);
        f3  = int'(ins[14:12]);
        alt = ins[30];
        if (c == 4) return (f3 < 4) ? 4'd1 : ((f3 < 6) ? 4'd8 : 4'd9);
        if (c == 0 && f3 == 0 && alt) return 4'd1;
        if ((c == 0 || c == 1) && f3 == 5 && alt) return 4'd7;
        if (c == 0 || c == 1) return tbl[f3];
        return 4'd0;
    endfunction

    function automatic bit exp_taken(input logic [31:0] ins, input bit z, input bit l);
        case (ins[14:12])
            3'd0:    return z;
            3'd1:    return !z;
            3'd4:    return l;
            3'd5:    return !l;
            3'd6:    return l;
            3'd7:    return !l;
            default: return 1'b0;
        endcase
    endfunction

    function automatic cyc_t blank(input bit rv);
        cyc_t e;
        e       = '{default: 0};
        e.run   = rv;
        e.iack  = 1'($urandom_range(0, 1));
        e.dack  = 1'($urandom_range(0, 1));
        e.z     = 1'($urandom_range(0, 1));
        e.l     = 1'($urandom_range(0, 1));
        e.rdata = $urandom;
        return e;
    endfunction

    task automatic gen_idle(input int n, input bit last_run);
        cyc_t e;
        for (int i = 0; i < n; i++) begin
            e        = blank((i == n - 1) ? last_run : 1'b0);
            e.halted = 1'b1;
            drive_q.push_back(e);
        end
    endtask

    // Expected trace of one instruction starting in its first fetch cycle
    task automatic gen(input logic [31:0] ins, input int iw, input int dw,
                       input bit z, input bit l, input bit rv);
        cyc_t e;
        int   c;
        c = iclass(ins);
        for (int k = 0; k <= iw; k++) begin
            e          = blank(rv);
            e.imem_req = 1'b1;
            e.iack     = (k == iw);
            e.rdata    = (k == iw) ? ins : $urandom;
            drive_q.push_back(e);
        end
        e           = blank(rv);
        e.chk_instr = 1'b1;
        e.instr     = ins;
        if (c == 6) begin
            e.ill   = 1'b1;
            e.pc_en = 1'b1;
            drive_q.push_back(e);
            return;
        end
        drive_q.push_back(e);
        e           = blank(rv);
        e.chk_instr = 1'b1;
        e.instr     = ins;
        e.chk_alu   = 1'b1;
        e.alu       = exp_alu(ins);
        e.chk_ab    = (c != 4);
        e.a         = 1'b1;
        e.b         = (c != 0);
        e.z         = z;
        e.l         = l;
        if (c == 4) begin
            e.pc_en = 1'b1;
            e.selb  = exp_taken(ins, z, l);
        end
        if (c == 5) begin
            e.pc_en = 1'b1;
            e.jump  = 1'b1;
        end
        drive_q.push_back(e);
        if (c == 2 || c == 3) begin
            for (int k = 0; k <= dw; k++) begin
                e           = blank(rv);
                e.chk_instr = 1'b1;
                e.instr     = ins;
                e.dmem_req  = 1'b1;
                e.dmem_we   = (c == 3);
                e.dack      = (k == dw);
                e.pc_en     = (c == 3) && (k == dw);
                drive_q.push_back(e);
            end
        end
        if (c == 0 || c == 1 || c == 2) begin
            e           = blank(rv);
            e.chk_instr = 1'b1;
            e.instr     = ins;
            e.regwrite  = 1'b1;
            e.pc_en     = 1'b1;
            e.memtoreg  = (c == 2);
            drive_q.push_back(e);
        end
    endtask

    task automatic play(input int n);
        cyc_t e;
        int   cnt;
        cnt = 0;
        while (drive_q.size() > 0 && cnt < n) begin
            e = drive_q.pop_front();
            @(posedge clock);
            #1;
            run           = e.run;
            imem_ack      = e.iack;
            dmem_ack      = e.dack;
            imem_rdata    = e.rdata;
            zero          = e.z;
            LSb_aluresult = e.l;
            cmp_q.push_back(e);
            cnt++;
        end
        drive_q.delete();
    endtask

    task automatic play_all();
        play(1 << 30);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        int c, v;
        r = $urandom;
        c = $urandom_range(0, 6);
        case (c)
            0: begin
                r[6:0]   = 7'b0110011;
                r[31:25] = {1'b0, r[30], 5'b0};
            end
            1: begin
                r[6:0] = 7'b0010011;
                if (r[13:12] == 2'b01) r[31:25] = {1'b0, r[14] & r[30], 5'b0};
            end
            2: r[6:0] = 7'b0000011;
            3: r[6:0] = 7'b0100011;
            4: begin
                r[6:0]   = 7'b1100011;
                v        = $urandom_range(0, 5);
                r[14:12] = 3'((v < 2) ? v : v + 2);
            end
            5: begin
                r[6:0]   = 7'b1100111;
                r[14:12] = 3'b000;
            end
            default: begin
                do r[6:0] = 7'($urandom); while (iclass(r) != 6);
            end
        endcase
        return r;
    endfunction

    always @(negedge clock) begin : compare_proc
        cyc_t e;
        if (cmp_q.size() > 0) begin
            e = cmp_q.pop_front();
            chk("imem_req", imem_req, e.imem_req);
            chk("dmem_req", dmem_req, e.dmem_req);
            chk("dmem_we", dmem_we, e.dmem_we);
            chk("pc_en", pc_en, e.pc_en);
            chk("regwrite", regwrite, e.regwrite);
            chk("memtoreg", memtoreg, e.memtoreg);
            chk("selBranch", selBranch, e.selb);
            chk("jump", jump, e.jump);
            chk("illegal_instr", illegal_instr, e.ill);
            chk("halted", halted, e.halted);
            if (e.chk_alu) chk("aluControl", aluControl, e.alu);
            if (e.chk_ab) begin
                chk("alusrcA", alusrcA, e.a);
                chk("alusrcB", alusrcB, e.b);
            end
            if (e.chk_instr) chk("instr", instr, e.instr);
        end
    end

    initial begin : stim
        int dcount;
        #12;
        chk("rst_halted", halted, 1);
        chk("rst_instr", instr, 32'h0000_0013);
        chk("rst_alu", aluControl, 0);
        chk("rst_imem_req", imem_req, 0);
        chk("rst_dmem_req", dmem_req, 0);
        chk("rst_pc_en", pc_en, 0);
        chk("rst_regwrite", regwrite, 0);
        chk("rst_alusrcA", alusrcA, 0);
`ifdef MCTRL_PERF_CNT_EN
        chk("rst_retired", retired_cnt, 0);
        chk("rst_stall", stall_cnt, 0);
`endif
        // Literal pins on the model itself
        chk("pin_alu_sub", exp_alu(32'h4000_0033), 4'd1);
        chk("pin_alu_srai", exp_alu(32'h4000_5013), 4'd7);
        chk("pin_alu_addi_b30", exp_alu(32'h4000_0013), 4'd0);
        chk("pin_beq_z1", exp_taken(32'h0020_8063, 1, 0), 1);
        chk("pin_bne_z1", exp_taken(32'h0020_9063, 1, 0), 0);

        @(negedge clock);
        reset_ = 1'b1;
        gen_idle(3, 1'b1);
        play_all();

        // Three instructions with two wait cycles in total, ending back in IDLE
        gen(32'h0020_81B3, 1, 0, 0, 0, 1'b1);
        gen(32'h0000_A183, 0, 1, 0, 0, 1'b1);
        gen(32'h0020_81B3, 0, 0, 0, 0, 1'b0);
        gen_idle(1, 1'b0);
        play_all();
`ifdef MCTRL_PERF_CNT_EN
        chk("perf_retired", retired_cnt, 3);
        chk("perf_stall", stall_cnt, 2);
`endif

        gen_idle(1, 1'b1);
        play_all();
        gen(32'h0020_81B3, 0, 0, 0, 0, 1'b1);
        chk("pin_add_len", drive_q.size(), 4);
        chk("pin_add_alu", drive_q[2].alu, 4'd0);
        chk("pin_add_srcB", drive_q[2].b, 0);
        chk("pin_add_wb", drive_q[3].regwrite & drive_q[3].pc_en, 1);
        play_all();

        gen(32'h0000_A183, 0, 3, 0, 0, 1'b1);
        dcount = 0;
        foreach (drive_q[i]) if (drive_q[i].dmem_req) dcount++;
        chk("pin_lw_dreq_cycles", dcount, 4);
        chk("pin_lw_len", drive_q.size(), 8);
        chk("pin_lw_memtoreg", drive_q[7].memtoreg, 1);
        play_all();

        gen(32'h0020_8063, 0, 0, 1, 0, 1'b1);
        gen(32'h0020_9063, 0, 0, 1, 0, 1'b1);
        gen(32'h0000_007F, 0, 0, 0, 0, 1'b1);
        play_all();

        for (int i = 0; i < 150; i++) begin
            gen(rand_instr(), $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
            play_all();
        end

        gen(32'h0020_81B3, 0, 0, 0, 0, 1'b0);
        gen_idle(3, 1'b0);
        play_all();

        // Asynchronous reset in the middle of a data handshake
        gen_idle(1, 1'b1);
        gen(32'h0000_A183, 0, 10, 0, 0, 1'b1);
        play(7);
        @(negedge clock);
        #2;
        reset_ = 1'b0;
        #1;
        chk("abort_dmem_req", dmem_req, 0);
        chk("abort_halted", halted, 1);
        chk("abort_instr", instr, 32'h0000_0013);
        chk("abort_imem_req", imem_req, 0);
        chk("abort_pc_en", pc_en, 0);
        run = 1'b0;
        @(negedge clock);
        reset_ = 1'b1;
        gen_idle(3, 1'b0);
        play_all();

        @(negedge clock);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
